// File: rtl/operand_fetch_stage.sv
// Decode/operand-fetch stage: decodes the instruction, reads rs/rt from the register file
// with EX/WB bypass, and holds the ALU operands in the OF->EX pipeline register.
module operand_fetch_stage #(
  parameter int unsigned DATA_W   = 32,
  parameter bit          FWD_EN   = 1'b1,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_aluop,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [4:0]        out_rd,
  output logic              out_wen,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              wb_we,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data
);

  typedef enum logic {EMPTY, FULL} state_t;

  localparam logic [2:0] ALU_NOP = 3'b111;

  state_t              state_q, state_d;
  logic [2:0]          aluop_q, aluop_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [4:0]          rd_q, rd_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   regs_q [32];

  logic [2:0]          dec_aluop;
  logic [4:0]          dec_rd, dec_rs, dec_rt;
  logic                dec_use_imm;
  logic [12:0]         dec_imm;
  logic [DATA_W-1:0]   imm_ext;
  logic [DATA_W-1:0]   rs_val, rt_val;
  logic                accept;
  logic                rf_we;

  assign dec_aluop   = in_instr[31:29];
  assign dec_rd      = in_instr[28:24];
  assign dec_rs      = in_instr[23:19];
  assign dec_rt      = in_instr[18:14];
  assign dec_use_imm = in_instr[13];
  assign dec_imm     = in_instr[12:0];
  assign imm_ext     = {{(DATA_W-13){dec_imm[12]}}, dec_imm};

  assign out_valid = (state_q == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign rf_we     = wb_we && !(ZERO_REG && (wb_addr == 5'd0));

  assign out_aluop = aluop_q;
  assign out_a     = a_q;
  assign out_b     = b_q;
  assign out_rd    = rd_q;
  assign out_wen   = wen_q;

  // EX result outranks WB data: the instruction in EX is the younger producer.
  function automatic logic [DATA_W-1:0] sel_operand(
    input logic [4:0]        addr,
    input logic [DATA_W-1:0] rf_val
  );
    if (ZERO_REG && (addr == 5'd0))
      return '0;
    else if (FWD_EN && out_valid && wen_q && (rd_q == addr))
      return ex_result;
    else if (FWD_EN && wb_we && (wb_addr == addr))
      return wb_data;
    else
      return rf_val;
  endfunction

  always_comb begin
    rs_val = sel_operand(dec_rs, regs_q[dec_rs]);
    rt_val = sel_operand(dec_rt, regs_q[dec_rt]);
  end

  always_comb begin
    state_d = state_q;
    aluop_d = aluop_q;
    a_d     = a_q;
    b_d     = b_q;
    rd_d    = rd_q;
    wen_d   = wen_q;
    if (accept) begin
      state_d = FULL;
      aluop_d = dec_aluop;
      a_d     = rs_val;
      b_d     = dec_use_imm ? imm_ext : rt_val;
      rd_d    = dec_rd;
      wen_d   = (dec_aluop != ALU_NOP) && !(ZERO_REG && (dec_rd == 5'd0));
    end else if (out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      aluop_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      aluop_q <= aluop_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rd_q    <= rd_d;
      wen_q   <= wen_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (rf_we) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

endmodule
